idu_ins_queue: RTL and testbench

//  Decode-side receiver of the IFU->IDU fetch stream. Buffers fetched words in a small queue,

---
 rtl/idu_ins_queue.sv | 141 ++++++++++++++
 tb/tb_idu_ins_queue.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/idu_ins_queue.sv
// Decode-side receiver of the IFU->IDU fetch stream: a small FIFO of {ins,pc} beats,
// WFI parking FSM, and combinational RV32I field/immediate decode of the queue head.
module idu_ins_queue #(
    parameter int DEPTH = 2,
    parameter int XLEN  = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_vld,
    input  logic            alu_ifu_br_vld,
    input  logic            ifu_idu_vld,
    input  logic [31:0]     ifu_idu_ins,
    input  logic [XLEN-1:0] ifu_idu_pc,
    output logic            idu_ifu_rdy,
    output logic            idu_ifu_wfi,
    input  logic            alu_idu_rdy,
    output logic            idu_alu_vld,
    output logic [XLEN-1:0] idu_alu_pc,
    output logic [6:0]      idu_alu_opcode,
    output logic [4:0]      idu_alu_rd,
    output logic [2:0]      idu_alu_funct3,
    output logic [4:0]      idu_alu_rs1,
    output logic [4:0]      idu_alu_rs2,
    output logic [6:0]      idu_alu_funct7,
    output logic [31:0]     idu_alu_imm,
    output logic            idu_alu_ill
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [31:0] WFI_INS = 32'h1050_0073;

    typedef enum logic {ST_RUN, ST_WFI} state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [31:0]     ins_mem [DEPTH];
    logic [XLEN-1:0] pc_mem  [DEPTH];

    logic        flush;
    logic        accept;
    logic        is_wfi;
    logic        push;
    logic        pop;
    logic [31:0] head_ins;

    assign flush       = start_vld | alu_ifu_br_vld;
    assign idu_ifu_rdy = (state_q == ST_RUN) && (count_q < CW'(DEPTH)) && !flush;
    assign idu_ifu_wfi = (state_q == ST_WFI);
    assign accept      = ifu_idu_vld & idu_ifu_rdy;
    assign is_wfi      = (ifu_idu_ins == WFI_INS);
    // The WFI word itself only changes state; it never occupies a slot.
    assign push        = accept & ~is_wfi;
    assign idu_alu_vld = (count_q != '0);
    assign pop         = idu_alu_vld & alu_idu_rdy & ~flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:  if (accept && is_wfi) state_d = ST_WFI;
            ST_WFI:  if (start_vld)        state_d = ST_RUN;
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_RUN;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: contents are only observed while count is non-zero.
    always_ff @(posedge clk) begin
        if (push) begin
            ins_mem[wr_ptr_q] <= ifu_idu_ins;
            pc_mem[wr_ptr_q]  <= ifu_idu_pc;
        end
    end

    assign head_ins       = ins_mem[rd_ptr_q];
    assign idu_alu_pc     = pc_mem[rd_ptr_q];
    assign idu_alu_opcode = head_ins[6:0];
    assign idu_alu_rd     = head_ins[11:7];
    assign idu_alu_funct3 = head_ins[14:12];
    assign idu_alu_rs1    = head_ins[19:15];
    assign idu_alu_rs2    = head_ins[24:20];
    assign idu_alu_funct7 = head_ins[31:25];

    always_comb begin
        idu_alu_imm = '0;
        idu_alu_ill = 1'b0;
        case (head_ins[6:0])
            7'b0000011, 7'b0010011, 7'b1100111:
                idu_alu_imm = {{20{head_ins[31]}}, head_ins[31:20]};
            7'b0100011:
                idu_alu_imm = {{20{head_ins[31]}}, head_ins[31:25], head_ins[11:7]};
            7'b1100011:
                idu_alu_imm = {{20{head_ins[31]}}, head_ins[7], head_ins[30:25],
                               head_ins[11:8], 1'b0};
            7'b0110111, 7'b0010111:
                idu_alu_imm = {head_ins[31:12], 12'b0};
            7'b1101111:
                idu_alu_imm = {{12{head_ins[31]}}, head_ins[19:12], head_ins[20],
                               head_ins[30:21], 1'b0};
            7'b0110011, 7'b1110011, 7'b0001111:
                idu_alu_imm = '0;
            default:
                idu_alu_ill = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_idu_ins_queue.sv
// Scoreboard bench for idu_ins_queue: a queue-based reference model tracks accepted beats,
// and a monitor checks every presented op against the model's decode of the expected word.
module tb_idu_ins_queue;

    localparam int DEPTH = 2;
    localparam int XLEN  = 32;
    localparam logic [31:0] WFI_INS = 32'h1050_0073;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_vld = 1'b0;
    logic        alu_ifu_br_vld = 1'b0;
    logic        ifu_idu_vld = 1'b0;
    logic [31:0] ifu_idu_ins = '0;
    logic [31:0] ifu_idu_pc = '0;
    logic        idu_ifu_rdy;
    logic        idu_ifu_wfi;
    logic        alu_idu_rdy = 1'b0;
    logic        idu_alu_vld;
    logic [31:0] idu_alu_pc;
    logic [6:0]  idu_alu_opcode;
    logic [4:0]  idu_alu_rd;
    logic [2:0]  idu_alu_funct3;
    logic [4:0]  idu_alu_rs1;
    logic [4:0]  idu_alu_rs2;
    logic [6:0]  idu_alu_funct7;
    logic [31:0] idu_alu_imm;
    logic        idu_alu_ill;

    idu_ins_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk(clk), .rst(rst), .start_vld(start_vld), .alu_ifu_br_vld(alu_ifu_br_vld),
        .ifu_idu_vld(ifu_idu_vld), .ifu_idu_ins(ifu_idu_ins), .ifu_idu_pc(ifu_idu_pc),
        .idu_ifu_rdy(idu_ifu_rdy), .idu_ifu_wfi(idu_ifu_wfi), .alu_idu_rdy(alu_idu_rdy),
        .idu_alu_vld(idu_alu_vld), .idu_alu_pc(idu_alu_pc), .idu_alu_opcode(idu_alu_opcode),
        .idu_alu_rd(idu_alu_rd), .idu_alu_funct3(idu_alu_funct3), .idu_alu_rs1(idu_alu_rs1),
        .idu_alu_rs2(idu_alu_rs2), .idu_alu_funct7(idu_alu_funct7), .idu_alu_imm(idu_alu_imm),
        .idu_alu_ill(idu_alu_ill)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] ins;
        logic [31:0] pc;
    } beat_t;

    beat_t sb[$];
    bit    wfi_m = 1'b0;
    bit    exp_rdy = 1'b0;
    int    n_checks = 0;
    int    n_fail = 0;

    logic [6:0] legal_opc [11] = '{7'b0000011, 7'b0010011, 7'b1100111, 7'b0100011,
                                   7'b1100011, 7'b0110111, 7'b0010111, 7'b1101111,
                                   7'b0110011, 7'b1110011, 7'b0001111};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit ref_ill(input logic [31:0] w);
        bit found = 1'b0;
        for (int i = 0; i < 11; i++) if (w[6:0] == legal_opc[i]) found = 1'b1;
        return !found;
    endfunction

    // Immediate built arithmetically from shifts and masks of the whole word.
    function automatic logic [31:0] ref_imm(input logic [31:0] w);
        logic [31:0] sgn;
        sgn = w[31] ? 32'hFFFF_FFFF : 32'h0;
        case (w[6:0])
            7'b0000011, 7'b0010011, 7'b1100111: return (sgn << 12) | (w >> 20);
            7'b0100011: return (sgn << 12) | ((w >> 25) << 5) | ((w >> 7) & 32'h1F);
            7'b1100011: return (sgn << 12) | (((w >> 7) & 32'h1) << 11)
                             | (((w >> 25) & 32'h3F) << 5) | (((w >> 8) & 32'hF) << 1);
            7'b0110111, 7'b0010111: return w & 32'hFFFF_F000;
            7'b1101111: return (sgn << 20) | (w & 32'h000F_F000) | (((w >> 20) & 32'h1) << 11)
                             | (((w >> 21) & 32'h3FF) << 1);
            default: return 32'h0;
        endcase
    endfunction

    // Monitor: samples 7 time units after each rising edge, pops on a real handshake.
    initial begin
        beat_t b;
        bit    exp_v;
        forever begin
            @(posedge clk);
            #7;
            exp_v = (sb.size() != 0);
            chk("alu_vld", 32'(idu_alu_vld), 32'(exp_v));
            if (exp_v && idu_alu_vld) begin
                b = sb[0];
                chk("alu_pc", idu_alu_pc, b.pc);
                chk("fields", {7'b0, idu_alu_funct7, idu_alu_rs2, idu_alu_rs1,
                               idu_alu_funct3, idu_alu_rd},
                              {7'b0, b.ins[31:7]});
                chk("opcode", 32'(idu_alu_opcode), 32'(b.ins[6:0]));
                chk("imm", idu_alu_imm, ref_imm(b.ins));
                chk("ill", 32'(idu_alu_ill), 32'(ref_ill(b.ins)));
                if (alu_idu_rdy && !rst && !start_vld && !alu_ifu_br_vld) begin
                    void'(sb.pop_front());
                    $display("op  pc=%h ins=%h imm=%h ill=%0d", b.pc, b.ins,
                             idu_alu_imm, idu_alu_ill);
                end
            end
        end
    end

    task automatic drive(input bit r, input bit st, input bit br, input bit v,
                         input logic [31:0] ins, input logic [31:0] pc, input bit ar);
        @(posedge clk);
        #2;
        rst = r; start_vld = st; alu_ifu_br_vld = br;
        ifu_idu_vld = v; ifu_idu_ins = ins; ifu_idu_pc = pc; alu_idu_rdy = ar;
        #1;
        exp_rdy = !wfi_m && (sb.size() < DEPTH) && !st && !br;
        chk("ifu_rdy", 32'(idu_ifu_rdy), 32'(exp_rdy));
        chk("ifu_wfi", 32'(idu_ifu_wfi), 32'(wfi_m));
    endtask

    // Applied after the monitor has taken this cycle's pop.
    task automatic commit();
        beat_t b;
        #5;
        if (rst) begin
            sb.delete();
            wfi_m = 1'b0;
        end else if (start_vld || alu_ifu_br_vld) begin
            sb.delete();
            if (start_vld) wfi_m = 1'b0;
        end else if (ifu_idu_vld && exp_rdy) begin
            if (ifu_idu_ins == WFI_INS) begin
                wfi_m = 1'b1;
            end else begin
                b.ins = ifu_idu_ins;
                b.pc  = ifu_idu_pc;
                sb.push_back(b);
            end
        end
    endtask

    task automatic idle(input bit ar);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, ar);
        commit();
    endtask

    task automatic send(input logic [31:0] ins, input logic [31:0] pc, input bit ar);
        bit done = 1'b0;
        for (int k = 0; k < 20 && !done; k++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b1, ins, pc, ar);
            done = exp_rdy;
            commit();
            ar = 1'b1;
        end
        n_checks++;
        if (!done) begin
            n_fail++;
            $display("FAIL send_timeout: got not-accepted expected accepted ins=%h", ins);
        end
    endtask

    initial begin
        logic [31:0] w;
        logic [6:0]  opc;
        logic [31:0] pc_r;
        int          sel;

        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        commit();
        idle(1'b0);

        // addi stream, in order, consumer always ready
        send(32'h0050_0093, 32'h0, 1'b1);
        send(32'h00A0_0113, 32'h4, 1'b1);
        idle(1'b1); idle(1'b1);

        // consumer stalled: third beat waits until a slot frees
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h0030_0193 + 32'(i << 7), 32'(8 + 4 * i), 1'b0);
            commit();
        end
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h0070_0213, 32'h10, 1'b0);
            commit();
        end
        send(32'h0070_0213, 32'h10, 1'b1);
        idle(1'b1); idle(1'b1);

        // redirect with a beat in flight discards everything
        send(32'h0010_0093, 32'h20, 1'b0);
        send(32'h0020_0113, 32'h24, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b1, 32'h0030_0193, 32'h28, 1'b1);
        commit();
        idle(1'b1);

        // WFI park then restart
        send(WFI_INS, 32'h30, 1'b1);
        idle(1'b1);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b1);
        commit();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        commit();
        idle(1'b1);

        // immediate / illegal corner words
        send(32'hFE00_0EE3, 32'h40, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        chk("beq_imm", idu_alu_imm, 32'hFFFF_FFFC);
        commit();
        send(32'h0000_007F, 32'h44, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        chk("illegal_flag", 32'(idu_alu_ill), 32'h1);
        commit();
        send(32'h8000_00B7, 32'h48, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        chk("lui_imm", idu_alu_imm, 32'h8000_0000);
        commit();
        idle(1'b1);

        // reset while full and parked
        send(32'h0010_0093, 32'h50, 1'b0);
        send(32'h0020_0113, 32'h54, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b1, WFI_INS, 32'h58, 1'b0);
        commit();
        idle(1'b0);
        send(WFI_INS, 32'h58, 1'b0);
        idle(1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        commit();
        idle(1'b0);

        // randomized traffic
        pc_r = 32'h100;
        for (int c = 0; c < 3000; c++) begin
            sel = $urandom_range(0, 13);
            w = $urandom();
            if (sel < 11) opc = legal_opc[sel];
            else if (sel == 11) opc = 7'h7F;
            else opc = 7'h00;
            w = {w[31:7], opc};
            if ($urandom_range(0, 19) == 0) w = WFI_INS;
            drive(($urandom_range(0, 99) == 0),
                  ($urandom_range(0, 19) == 0),
                  ($urandom_range(0, 24) == 0),
                  ($urandom_range(0, 9) < 7),
                  w, pc_r,
                  ($urandom_range(0, 9) < 6));
            if (ifu_idu_vld && exp_rdy) pc_r = pc_r + 32'h4;
            commit();
        end
        for (int c = 0; c < 4; c++) idle(1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
